// File: rtl/msg_rom_streamer_pkg.sv
// rtl/msg_rom_streamer_pkg.sv - shared states and character constants for the message streamer
package msg_rom_streamer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [7:0] CH_A   = 8'h41;
  localparam logic [7:0] CH_S   = 8'h53;
  localparam logic [7:0] CH_I   = 8'h49;
  localparam logic [7:0] CH_G   = 8'h47;
  localparam logic [7:0] CH_N   = 8'h4E;
  localparam logic [7:0] CH_M   = 8'h4D;
  localparam logic [7:0] CH_E   = 8'h45;
  localparam logic [7:0] CH_T   = 8'h54;
  localparam logic [7:0] CH_SP  = 8'h20;
  localparam logic [7:0] CH_NUL = 8'h00;

  localparam int MSG_DEFAULT_LEN = 11;

endpackage

// File: rtl/msg_rom_streamer_if.sv
// rtl/msg_rom_streamer_if.sv - character stream handshake bundle
interface msg_rom_streamer_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/msg_rom.sv
// rtl/msg_rom.sv - fixed "ASSIGNMENT " character table, zero beyond the message
module msg_rom
  import msg_rom_streamer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  // combinational lookup; narrower chars are zero-extended to DATA_W
  always_comb begin
    data = DATA_W'(CH_NUL);
    case (int'(addr))
      0:       data = DATA_W'(CH_A);
      1:       data = DATA_W'(CH_S);
      2:       data = DATA_W'(CH_S);
      3:       data = DATA_W'(CH_I);
      4:       data = DATA_W'(CH_G);
      5:       data = DATA_W'(CH_N);
      6:       data = DATA_W'(CH_M);
      7:       data = DATA_W'(CH_E);
      8:       data = DATA_W'(CH_N);
      9:       data = DATA_W'(CH_T);
      10:      data = DATA_W'(CH_SP);
      default: data = DATA_W'(CH_NUL);
    endcase
  end

endmodule

// File: rtl/msg_rom_streamer.sv
// rtl/msg_rom_streamer.sv - streams a programmable prefix of the message table over valid/ready
module msg_rom_streamer
  import msg_rom_streamer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int LEN_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  input  logic                  loop_en,
  input  logic                  abort,
  msg_rom_streamer_if.master    out_if,
  output logic                  busy,
  output logic                  done
);

  state_t              state, state_n;
  logic [ADDR_W-1:0]   idx, idx_n;
  logic [LEN_W-1:0]    len_q, len_n;
  logic                loop_q, loop_n;
  logic [DATA_W-1:0]   data_q, data_n;
  logic                valid_q, valid_n;
  logic                last_q, last_n;
  logic                done_q, done_n;

  logic [ADDR_W-1:0]   rom_addr;
  logic [DATA_W-1:0]   rom_data;
  logic [LEN_W-1:0]    len_clamp;
  logic                xfer;

  assign xfer      = valid_q && out_if.out_ready;
  assign len_clamp = (len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;

  msg_rom #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rom (
    .addr (rom_addr),
    .data (rom_data)
  );

  // address of the character to load next: idx+1 on a mid-pass transfer, else the pass start
  always_comb begin
    rom_addr = '0;
    if (state == STREAM && xfer && !last_q) begin
      rom_addr = idx + ADDR_W'(1);
    end
  end

  // next-state and next-output decisions; registered outputs are computed here one cycle ahead
  always_comb begin
    state_n = state;
    idx_n   = idx;
    len_n   = len_q;
    loop_n  = loop_q;
    data_n  = data_q;
    valid_n = valid_q;
    last_n  = last_q;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            done_n = 1'b1;
          end else begin
            len_n   = len_clamp;
            loop_n  = loop_en;
            idx_n   = '0;
            data_n  = rom_data;
            valid_n = 1'b1;
            last_n  = (len_clamp == LEN_W'(1));
            state_n = STREAM;
          end
        end
      end
      STREAM: begin
        if (abort) begin
          valid_n = 1'b0;
          last_n  = 1'b0;
          done_n  = 1'b1;
          state_n = DONE;
        end else if (xfer) begin
          if (!last_q) begin
            idx_n  = idx + ADDR_W'(1);
            data_n = rom_data;
            last_n = ((LEN_W'(idx) + LEN_W'(1)) == (len_q - LEN_W'(1)));
          end else if (loop_q) begin
            idx_n  = '0;
            data_n = rom_data;
            last_n = (len_q == LEN_W'(1));
          end else begin
            valid_n = 1'b0;
            last_n  = 1'b0;
            done_n  = 1'b1;
            state_n = DONE;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
        last_n  = 1'b0;
      end
    endcase
  end

  // state and output registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      len_q   <= '0;
      loop_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      len_q   <= len_n;
      loop_q  <= loop_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      last_q  <= last_n;
      done_q  <= done_n;
    end
  end

  assign out_if.out_data  = data_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_last  = last_q;
  assign busy             = (state == STREAM);
  assign done             = done_q;

endmodule

// File: tb/tb_msg_rom_streamer.sv
// tb/tb_msg_rom_streamer.sv - directed self-checking bench for msg_rom_streamer
module tb_msg_rom_streamer;
  import msg_rom_streamer_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int LEN_W  = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             loop_en;
  logic             abort;
  logic             busy;
  logic             done;

  int checks   = 0;
  int failures = 0;

  logic [7:0] beat_data [64];
  logic       beat_last [64];

  msg_rom_streamer_if #(.DATA_W(DATA_W)) sif ();

  msg_rom_streamer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .len     (len),
    .loop_en (loop_en),
    .abort   (abort),
    .out_if  (sif.master),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_char(input int a);
    case (a)
      0: return 8'h41;  1: return 8'h53;  2: return 8'h53;  3: return 8'h49;
      4: return 8'h47;  5: return 8'h4E;  6: return 8'h4D;  7: return 8'h45;
      8: return 8'h4E;  9: return 8'h54; 10: return 8'h20;
      default: return 8'h00;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n, input logic lp);
    start   = 1'b1;
    len     = LEN_W'(n);
    loop_en = lp;
    tick();
    start   = 1'b0;
  endtask

  // mode 0: ready always high; mode 1: ready high every third cycle
  task automatic collect(input int max_cyc, input int mode, input int start_at,
                         output int nbeats, output int done_gap);
    int   last_xfer;
    logic have_stall;
    logic [7:0] stall_d;
    logic stall_l;
    nbeats     = 0;
    last_xfer  = -100;
    done_gap   = -1;
    have_stall = 1'b0;
    stall_d    = '0;
    stall_l    = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      sif.out_ready = (mode == 0) ? 1'b1 : ((c % 3) == 0);
      start = (c == start_at);
      if (have_stall) begin
        check("stall_valid", 32'(sif.out_valid), 32'd1);
        check("stall_data", 32'(sif.out_data), 32'(stall_d));
        check("stall_last", 32'(sif.out_last), 32'(stall_l));
        have_stall = 1'b0;
      end
      if (done) begin
        done_gap = c - last_xfer;
        break;
      end
      if (sif.out_valid && sif.out_ready) begin
        if (nbeats < 64) begin
          beat_data[nbeats] = sif.out_data;
          beat_last[nbeats] = sif.out_last;
        end
        nbeats++;
        last_xfer = c;
      end else if (sif.out_valid) begin
        have_stall = 1'b1;
        stall_d    = sif.out_data;
        stall_l    = sif.out_last;
      end
      tick();
    end
    start = 1'b0;
    sif.out_ready = 1'b1;
  endtask

  task automatic check_run(input string tag, input int nexp, input int nbeats, input int gap);
    check({tag, "_count"}, 32'(nbeats), 32'(nexp));
    for (int i = 0; i < nexp && i < nbeats; i++) begin
      check($sformatf("%s_data%0d", tag, i), 32'(beat_data[i]), 32'(exp_char(i)));
      check($sformatf("%s_last%0d", tag, i), 32'(beat_last[i]), 32'(i == nexp - 1));
    end
    check({tag, "_done_gap"}, 32'(gap), 32'd1);
    check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    check({tag, "_valid_in_done"}, 32'(sif.out_valid), 32'd0);
    tick();
    check({tag, "_done_pulse_end"}, 32'(done), 32'd0);
  endtask

  initial begin
    int nb;
    int gap;
    int dcount;
    rst           = 1'b1;
    start         = 1'b0;
    len           = '0;
    loop_en       = 1'b0;
    abort         = 1'b0;
    sif.out_ready = 1'b1;
    #1;
    check("rst_valid", 32'(sif.out_valid), 32'd0);
    check("rst_data", 32'(sif.out_data), 32'd0);
    check("rst_last", 32'(sif.out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // full message, one-shot
    do_start(MSG_DEFAULT_LEN, 1'b0);
    check("t1_first_valid", 32'(sif.out_valid), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    collect(40, 0, -1, nb, gap);
    check_run("t1", 11, nb, gap);

    // len 4 with back-pressure
    do_start(4, 1'b0);
    collect(60, 1, -1, nb, gap);
    check_run("t2", 4, nb, gap);

    // looping 3-char pass, then abort
    do_start(3, 1'b1);
    nb = 0;
    dcount = 0;
    sif.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (done) dcount++;
      if (sif.out_valid) begin
        beat_data[nb] = sif.out_data;
        beat_last[nb] = sif.out_last;
        nb++;
      end
      tick();
    end
    check("t3_count", 32'(nb), 32'd10);
    for (int i = 0; i < nb && i < 10; i++) begin
      check($sformatf("t3_data%0d", i), 32'(beat_data[i]), 32'(exp_char(i % 3)));
      check($sformatf("t3_last%0d", i), 32'(beat_last[i]), 32'((i % 3) == 2));
    end
    check("t3_no_done", 32'(dcount), 32'd0);
    sif.out_ready = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    sif.out_ready = 1'b1;
    check("t3_abort_valid", 32'(sif.out_valid), 32'd0);
    check("t3_abort_done", 32'(done), 32'd1);
    check("t3_abort_busy", 32'(busy), 32'd0);
    tick();
    check("t3_abort_done_end", 32'(done), 32'd0);
    check("t3_abort_idle_valid", 32'(sif.out_valid), 32'd0);

    // zero length
    do_start(0, 1'b0);
    check("t4_valid", 32'(sif.out_valid), 32'd0);
    check("t4_done", 32'(done), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    tick();
    check("t4_done_end", 32'(done), 32'd0);
    check("t4_valid_end", 32'(sif.out_valid), 32'd0);

    // over-length clamps to DEPTH
    do_start(31, 1'b0);
    collect(60, 0, -1, nb, gap);
    check_run("t5", 16, nb, gap);

    // start mid-stream ignored
    do_start(5, 1'b0);
    len = LEN_W'(15);
    collect(40, 0, 2, nb, gap);
    check_run("t6", 5, nb, gap);

    // asynchronous reset mid-stream
    do_start(11, 1'b0);
    tick();
    tick();
    check("t7_pre_valid", 32'(sif.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("t7_rst_valid", 32'(sif.out_valid), 32'd0);
    check("t7_rst_data", 32'(sif.out_data), 32'd0);
    check("t7_rst_last", 32'(sif.out_last), 32'd0);
    check("t7_rst_busy", 32'(busy), 32'd0);
    check("t7_rst_done", 32'(done), 32'd0);
    tick();
    check("t7_rst_no_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();
    check("t7_post_no_done", 32'(done), 32'd0);
    do_start(2, 1'b0);
    collect(20, 0, -1, nb, gap);
    check_run("t7", 2, nb, gap);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
